postprocess: RTL and testbench

Output-side counterpart of the channel-rotating pre-stage in the binarization pipeline. Accepts the processed 24-bit pixel stream with its sync signals, restores the original channel order and re-aligns video and syncs through a configurable register pipeline. It also generates per-pixel coordinates and a frame-start strobe for the display or overlay stage that follows. It sits between the processing core and the video output encoder.

---
 rtl/postprocess_pkg.sv | 30 +++
 rtl/vid_delay_line.sv | 23 ++
 rtl/postprocess.sv | 91 +++++++++
 tb/tb_postprocess.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/postprocess_pkg.sv
// Shared widths, channel layout of the rotated pixel format and the beat carried
// down the output delay line.
package postprocess_pkg;
    localparam int PIX_W   = 24;
    localparam int COORD_W = 12;

    // Rotated input layout: [23:16]=G, [15:8]=B, [7:0]=R
    localparam int G_MSB = 23;
    localparam int G_LSB = 16;
    localparam int B_MSB = 15;
    localparam int B_LSB = 8;
    localparam int R_MSB = 7;
    localparam int R_LSB = 0;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    typedef struct packed {
        logic               fs;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        logic               vs;
        logic               hs;
        logic               de;
        logic [PIX_W-1:0]   pix;
    } beat_t;

    function automatic logic [PIX_W-1:0] unswizzle(input logic [PIX_W-1:0] p);
        return {p[R_MSB:R_LSB], p[G_MSB:G_LSB], p[B_MSB:B_LSB]};
    endfunction
endpackage

// File: rtl/vid_delay_line.sv
// Fixed-depth register shift line with asynchronous active-low clear.
module vid_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [DEPTH-1:0][W-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/postprocess.sv
// Channel restore, coordinate/frame-start generation and DELAY-stage re-alignment.
// Optional line/frame geometry checker enabled by POSTPROCESS_GEOM_CHECK_EN.
module postprocess
    import postprocess_pkg::*;
#(
    parameter int DELAY    = 1,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic [PIX_W-1:0]   video_in,
    output logic               de_out,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic [PIX_W-1:0]   video_out,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic               frame_start,
    output logic               geom_err
);
    logic               de_q, vs_q, armed;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic               de_fall, vs_rise;
    beat_t              beat_in, beat_out;

    assign de_fall = de_q & ~de_in;
    assign vs_rise = v_sync_in & ~vs_q;

    // x_cnt is zero on the first active cycle of every line, so it doubles as the pixel index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q  <= 1'b0;
            vs_q  <= 1'b0;
            armed <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            de_q <= de_in;
            vs_q <= v_sync_in;
            if (vs_rise) armed <= 1'b1;
            if (!de_in)                   x_cnt <= '0;
            else if (x_cnt != COORD_MAX)  x_cnt <= x_cnt + 1'b1;
            if (vs_rise)                              y_cnt <= '0;
            else if (de_fall && y_cnt != COORD_MAX)   y_cnt <= y_cnt + 1'b1;
        end
    end

    always_comb begin
        beat_in     = '0;
        beat_in.de  = de_in;
        beat_in.hs  = h_sync_in;
        beat_in.vs  = v_sync_in;
        beat_in.pix = de_in ? unswizzle(video_in) : '0;
        beat_in.x   = de_in ? x_cnt : '0;
        beat_in.y   = y_cnt;
        beat_in.fs  = de_in && (x_cnt == '0) && (y_cnt == '0) && armed;
    end

    vid_delay_line #(.W($bits(beat_t)), .DEPTH(DELAY)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (beat_in),
        .q     (beat_out)
    );

    assign de_out      = beat_out.de;
    assign h_sync_out  = beat_out.hs;
    assign v_sync_out  = beat_out.vs;
    assign video_out   = beat_out.pix;
    assign x_pos       = beat_out.x;
    assign y_pos       = beat_out.y;
    assign frame_start = beat_out.fs;

`ifdef POSTPROCESS_GEOM_CHECK_EN
    // Only checked once armed, so the partial frame after reset never flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            geom_err <= 1'b0;
        end else if (armed && ((de_fall && x_cnt != COORD_W'(H_ACTIVE)) ||
                               (vs_rise && y_cnt != COORD_W'(V_ACTIVE)))) begin
            geom_err <= 1'b1;
        end
    end
`else
    assign geom_err = 1'b0;
`endif
endmodule

// File: tb/tb_postprocess.sv
// Directed bench for postprocess: DELAY=1 and DELAY=3 instances share stimulus,
// each vector's expected output is checked DELAY cycles after it is applied.
module tb_postprocess;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
    logic [23:0] video_in = '0;

    logic        de1, hs1, vs1, fs1, ge1;
    logic [23:0] vid1;
    logic [11:0] x1, y1;
    logic        de3, hs3, vs3, fs3, ge3;
    logic [23:0] vid3;
    logic [11:0] x3, y3;

    always #5 clk = ~clk;

    postprocess #(.DELAY(1), .H_ACTIVE(4), .V_ACTIVE(2)) u1 (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .video_in(video_in), .de_out(de1),
        .h_sync_out(hs1), .v_sync_out(vs1), .video_out(vid1), .x_pos(x1),
        .y_pos(y1), .frame_start(fs1), .geom_err(ge1));

    postprocess #(.DELAY(3), .H_ACTIVE(4), .V_ACTIVE(2)) u3 (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .video_in(video_in), .de_out(de3),
        .h_sync_out(hs3), .v_sync_out(vs3), .video_out(vid3), .x_pos(x3),
        .y_pos(y3), .frame_start(fs3), .geom_err(ge3));

    typedef struct packed {
        logic        de, hs, vs;
        logic [23:0] vid;
        logic [11:0] x, y;
        logic        fs;
    } exp_t;

    exp_t hist [0:8191];
    int   n = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic ge_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Coordinates only carry meaning while de is high, so they are masked otherwise
    task automatic cmp_dut(input string who, input exp_t e, input logic de, hs, vs,
                           input logic [23:0] vid, input logic [11:0] x, y, input logic fs);
        chk({who, ".de"}, 32'(de), 32'(e.de));
        chk({who, ".hs"}, 32'(hs), 32'(e.hs));
        chk({who, ".vs"}, 32'(vs), 32'(e.vs));
        chk({who, ".video"}, 32'(vid), 32'(e.vid));
        chk({who, ".fs"}, 32'(fs), 32'(e.fs));
        if (e.de) begin
            chk({who, ".x"}, 32'(x), 32'(e.x));
            chk({who, ".y"}, 32'(y), 32'(e.y));
        end
    endtask

    task automatic check_outs();
        if (n >= 1) cmp_dut("d1", hist[n-1], de1, hs1, vs1, vid1, x1, y1, fs1);
        if (n >= 3) cmp_dut("d3", hist[n-3], de3, hs3, vs3, vid3, x3, y3, fs3);
        chk("d1.geom_err", 32'(ge1), 32'(ge_exp));
        chk("d3.geom_err", 32'(ge3), 32'(ge_exp));
    endtask

    task automatic step(input logic de, hs, vs, input logic [23:0] pix,
                        input int ex, ey, input logic efs);
        exp_t e;
        @(negedge clk);
        check_outs();
        de_in = de; h_sync_in = hs; v_sync_in = vs; video_in = pix;
        e.de = de; e.hs = hs; e.vs = vs;
        e.vid = de ? {pix[7:0], pix[23:16], pix[15:8]} : 24'h0;
        e.x = 12'(ex); e.y = 12'(ey); e.fs = efs;
        if (!rst_n) e = '0;
        hist[n] = e;
        n++;
    endtask

    task automatic idle(input logic hs, vs);
        step(1'b0, hs, vs, 24'h0, 0, 0, 1'b0);
    endtask

    task automatic line(input int len, input int y, input logic fs_first, input logic [23:0] base);
        for (int i = 0; i < len; i++)
            step(1'b1, 1'b0, 1'b0, base + 24'(i), (i > 4095) ? 4095 : i, y, fs_first && i == 0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".d1"}, {de1, hs1, vs1, fs1, ge1, vid1[23:0] == 24'h0, x1 == 12'h0, y1 == 12'h0},
            {8'b0000_0111});
        chk({tag, ".d3"}, {de3, hs3, vs3, fs3, ge3, vid3[23:0] == 24'h0, x3 == 12'h0, y3 == 12'h0},
            {8'b0000_0111});
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        check_outs();
        rst_n = 1'b0;
        ge_exp = 1'b0;
        for (int k = 1; k <= 3; k++) if (n - k >= 0) hist[n-k] = '0;
        hist[n] = '0;
        n++;
        #1 all_zero("rst_mid");
        step(1'b1, 1'b0, 1'b0, 24'hDEAD00, 0, 0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        all_zero("rst_init");
        rst_n = 1'b1;

        step(1'b1, 1'b0, 1'b0, 24'h112233, 0, 0, 1'b0);
        idle(0, 0);
        chk("d1.restore_112233", 32'(vid1), 32'h331122);
        idle(0, 0);

        // vsync pulse then a correct 4x2 frame
        idle(0, 1); idle(0, 1); idle(1, 0); idle(0, 0);
        line(4, 0, 1'b1, 24'h010203); idle(1, 0); idle(0, 0);
        line(4, 1, 1'b0, 24'h102030); idle(0, 0); idle(0, 0);

        // frame with a 5-pixel first line
        idle(0, 1); idle(0, 0);
        line(5, 0, 1'b1, 24'hA0B0C0); idle(0, 0);
`ifdef POSTPROCESS_GEOM_CHECK_EN
        ge_exp = 1'b1;
`endif
        idle(0, 0);
        line(4, 1, 1'b0, 24'h0F1E2D); idle(0, 0); idle(0, 0);

        // correct frame: error must stay sticky
        idle(0, 1); idle(0, 0);
        line(4, 0, 1'b1, 24'h334455); idle(0, 0); idle(0, 0);
        line(4, 1, 1'b0, 24'h667788); idle(0, 0); idle(0, 0);

        // reset mid-line, then a partial frame that must not raise frame_start
        idle(0, 1); idle(0, 0);
        line(2, 0, 1'b1, 24'h5A5A00);
        rst_pulse();
        line(2, 0, 1'b0, 24'h777700); idle(0, 0); idle(0, 0);
        line(2, 1, 1'b0, 24'h888800); idle(0, 0); idle(0, 0);
        idle(0, 1); idle(0, 0);
        line(4, 0, 1'b1, 24'hC0FFEE); idle(0, 0); idle(0, 0);

        // overlong line: x saturates at 4095
        line(5000, 1, 1'b0, 24'h000000); idle(0, 0);
`ifdef POSTPROCESS_GEOM_CHECK_EN
        ge_exp = 1'b1;
`endif
        repeat (4) idle(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
